// File: rtl/ddr_requester_if.sv
// Request/acknowledge bus between the ddr_requester (master) and the DDR controller (slave).
// Read and write channels each carry their own request, address and acknowledge.
interface ddr_requester_if;
    logic        read;
    logic [23:0] readAddress;
    logic        readAcknowledge;
    logic [15:0] readData;
    logic        write;
    logic [23:0] writeAddress;
    logic [15:0] writeData;
    logic        writeAcknowledge;

    modport master (
        output read,
        output readAddress,
        input  readAcknowledge,
        input  readData,
        output write,
        output writeAddress,
        output writeData,
        input  writeAcknowledge
    );

    modport slave (
        input  read,
        input  readAddress,
        output readAcknowledge,
        output readData,
        input  write,
        input  writeAddress,
        input  writeData,
        output writeAcknowledge
    );
endinterface

// File: rtl/ddr_requester.sv
// DDR client front end: prefetches video lines into a double-buffered line RAM and
// drains a small pixel-write FIFO into DDR, one request/acknowledge round trip at a time.
module ddr_requester #(
    parameter int LINE_WORDS = 640,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk133_p,
    input  logic        rst,
    input  logic        lineStart,
    input  logic [23:0] lineBase,
    output logic        lineBusy,
    output logic        overrun,
    input  logic [9:0]  bufReadAddr,
    output logic [15:0] bufReadData,
    input  logic        pixelWrite,
    input  logic [23:0] pixelAddress,
    input  logic [15:0] pixelData,
    output logic        pixelReady,
    ddr_requester_if.master ddr
);

    localparam int WC_W  = $clog2(LINE_WORDS + 1);
    localparam int IDX_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [WC_W-1:0]  LAST_COUNT = WC_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DROP,
        WR_REQ,
        WR_DROP
    } state_t;

    state_t state;
    state_t state_next;

    logic            fill_bank;
    logic            display_bank;
    logic [WC_W-1:0] word_count;
    logic [23:0]     latched_base;
    logic [15:0]     line_mem [2][LINE_WORDS];
    logic            line_accept;
    logic            read_done;
    logic            read_release;
    logic            buf_in_range;

    logic [23:0]      fifo_addr [FIFO_DEPTH];
    logic [15:0]      fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;
    logic             fifo_empty;

    assign line_accept  = lineStart && !lineBusy;
    assign read_done    = (state == RD_REQ) && ddr.readAcknowledge;
    assign read_release = (state == RD_DROP) && !ddr.readAcknowledge;
    assign push         = pixelWrite && pixelReady;
    assign pop          = (state == WR_REQ) && ddr.writeAcknowledge;
    assign fifo_empty   = (fifo_count == '0);

    // The display side reads the bank not being filled; it flips on the same edge as fill_bank.
    assign display_bank = line_accept ? fill_bank : ~fill_bank;
    assign buf_in_range = int'(bufReadAddr) < LINE_WORDS;

    always_ff @(posedge clk133_p or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Reads win over writes; a request is only raised once its acknowledge has fallen.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (lineBusy) begin
                    if (!ddr.readAcknowledge) begin
                        state_next = RD_REQ;
                    end
                end else if (!fifo_empty && !ddr.writeAcknowledge) begin
                    state_next = WR_REQ;
                end
            end
            RD_REQ: begin
                if (ddr.readAcknowledge) begin
                    state_next = RD_DROP;
                end
            end
            RD_DROP: begin
                if (!ddr.readAcknowledge) begin
                    state_next = IDLE;
                end
            end
            WR_REQ: begin
                if (ddr.writeAcknowledge) begin
                    state_next = WR_DROP;
                end
            end
            WR_DROP: begin
                if (!ddr.writeAcknowledge) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ddr.read         = (state == RD_REQ);
    assign ddr.readAddress  = ddr.read ? (latched_base + 24'(word_count)) : '0;
    assign ddr.write        = (state == WR_REQ);
    assign ddr.writeAddress = ddr.write ? fifo_addr[rd_ptr] : '0;
    assign ddr.writeData    = ddr.write ? fifo_data[rd_ptr] : '0;

    always_ff @(posedge clk133_p or posedge rst) begin
        if (rst) begin
            fill_bank    <= 1'b0;
            word_count   <= '0;
            latched_base <= '0;
            lineBusy     <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (line_accept) begin
                fill_bank    <= ~fill_bank;
                word_count   <= '0;
                latched_base <= lineBase;
                lineBusy     <= 1'b1;
            end else begin
                if (read_done) begin
                    word_count <= word_count + 1'b1;
                end
                if (read_release && (word_count == LAST_COUNT)) begin
                    lineBusy <= 1'b0;
                end
            end
            if (lineStart && lineBusy) begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk133_p) begin
        if (read_done) begin
            line_mem[fill_bank][word_count[IDX_W-1:0]] <= ddr.readData;
        end
    end

    always_ff @(posedge clk133_p or posedge rst) begin
        if (rst) begin
            bufReadData <= '0;
        end else if (buf_in_range) begin
            bufReadData <= line_mem[display_bank][bufReadAddr[IDX_W-1:0]];
        end else begin
            bufReadData <= '0;
        end
    end

    always_comb begin
        count_next = fifo_count;
        case ({push, pop})
            2'b10:   count_next = fifo_count + 1'b1;
            2'b01:   count_next = fifo_count - 1'b1;
            default: count_next = fifo_count;
        endcase
    end

    always_ff @(posedge clk133_p) begin
        if (push) begin
            fifo_addr[wr_ptr] <= pixelAddress;
            fifo_data[wr_ptr] <= pixelData;
        end
    end

    // pixelReady is registered, so a push in the cycle the FIFO fills is still honoured only if it was low-count.
    always_ff @(posedge clk133_p or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            pixelReady <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= count_next;
            pixelReady <= (count_next < FULL_COUNT);
        end
    end

endmodule

// File: tb/tb_ddr_requester.sv
// Self-checking bench for ddr_requester: a DDR controller model compares every
// completed transaction against a scoreboard of expected transactions in order.
module tb_ddr_requester;

    localparam int LINE_WORDS = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int ACK_DELAY  = 6;

    logic        clk133_p = 1'b0;
    logic        rst = 1'b1;
    logic        lineStart = 1'b0;
    logic [23:0] lineBase = '0;
    logic        lineBusy;
    logic        overrun;
    logic [9:0]  bufReadAddr = '0;
    logic [15:0] bufReadData;
    logic        pixelWrite = 1'b0;
    logic [23:0] pixelAddress = '0;
    logic [15:0] pixelData = '0;
    logic        pixelReady;

    ddr_requester_if ddr ();

    ddr_requester #(
        .LINE_WORDS(LINE_WORDS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk133_p     (clk133_p),
        .rst          (rst),
        .lineStart    (lineStart),
        .lineBase     (lineBase),
        .lineBusy     (lineBusy),
        .overrun      (overrun),
        .bufReadAddr  (bufReadAddr),
        .bufReadData  (bufReadData),
        .pixelWrite   (pixelWrite),
        .pixelAddress (pixelAddress),
        .pixelData    (pixelData),
        .pixelReady   (pixelReady),
        .ddr          (ddr)
    );

    always #4 clk133_p = ~clk133_p;

    typedef struct packed {
        logic        is_write;
        logic [23:0] addr;
        logic [15:0] data;
    } txn_t;

    txn_t exp_q[$];
    int   check_count = 0;
    int   error_count = 0;
    int   reads_done = 0;
    int   writes_done = 0;
    bit   stall_writes = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic compareTxn(input txn_t observed);
        txn_t e;
        checkOutput("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("txn", 64'(observed), 64'(e));
        end
    endtask

    // DDR controller model: acknowledges each request ACK_DELAY cycles after it rises.
    initial begin
        int          rd_wait;
        int          wr_wait;
        bit          rd_seen;
        bit          wr_seen;
        logic [23:0] rd_hold;
        logic [39:0] wr_hold;
        rd_wait = 0;
        wr_wait = 0;
        rd_seen = 1'b0;
        wr_seen = 1'b0;
        rd_hold = '0;
        wr_hold = '0;
        ddr.readAcknowledge  = 1'b0;
        ddr.writeAcknowledge = 1'b0;
        ddr.readData         = '0;
        forever begin
            @(negedge clk133_p);
            if (rst) begin
                ddr.readAcknowledge  = 1'b0;
                ddr.writeAcknowledge = 1'b0;
                rd_wait = 0;
                wr_wait = 0;
                rd_seen = 1'b0;
                wr_seen = 1'b0;
            end else begin
                checkOutput("no_overlap", 64'(ddr.read & ddr.write), 64'd0);
                if (ddr.readAcknowledge) begin
                    ddr.readAcknowledge = 1'b0;
                end else if (ddr.read) begin
                    if (!rd_seen) begin
                        rd_seen = 1'b1;
                        rd_hold = ddr.readAddress;
                    end else begin
                        checkOutput("rd_addr_stable", 64'(ddr.readAddress), 64'(rd_hold));
                    end
                    rd_wait++;
                    if (rd_wait >= ACK_DELAY) begin
                        compareTxn({1'b0, ddr.readAddress, 16'h0000});
                        ddr.readData        = ddr.readAddress[15:0] ^ 16'hA5A5;
                        ddr.readAcknowledge = 1'b1;
                        rd_wait = 0;
                        rd_seen = 1'b0;
                        reads_done++;
                    end
                end
                if (ddr.writeAcknowledge) begin
                    ddr.writeAcknowledge = 1'b0;
                end else if (ddr.write) begin
                    if (!wr_seen) begin
                        wr_seen = 1'b1;
                        wr_hold = {ddr.writeAddress, ddr.writeData};
                    end else begin
                        checkOutput("wr_stable", 64'({ddr.writeAddress, ddr.writeData}), 64'(wr_hold));
                    end
                    if (!stall_writes) begin
                        wr_wait++;
                    end
                    if (wr_wait >= ACK_DELAY) begin
                        compareTxn({1'b1, ddr.writeAddress, ddr.writeData});
                        ddr.writeAcknowledge = 1'b1;
                        wr_wait = 0;
                        wr_seen = 1'b0;
                        writes_done++;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic [23:0] addr, input logic [15:0] data, input bit expect_write);
        pixelWrite   = 1'b1;
        pixelAddress = addr;
        pixelData    = data;
        if (expect_write) begin
            exp_q.push_back({1'b1, addr, data});
        end
        @(negedge clk133_p);
    endtask

    task automatic startLine(input logic [23:0] base, input bit expect_reads);
        @(negedge clk133_p);
        lineBase  = base;
        lineStart = 1'b1;
        if (expect_reads) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                exp_q.push_back({1'b0, base + 24'(i), 16'h0000});
            end
        end
        @(negedge clk133_p);
        lineStart = 1'b0;
        checkOutput("line_busy_set", 64'(lineBusy), 64'd1);
    endtask

    task automatic waitQuiet(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk133_p);
            if (!lineBusy && !ddr.read && !ddr.write && exp_q.size() == 0) begin
                break;
            end
        end
        repeat (3) @(negedge clk133_p);
        checkOutput("drain", 64'(exp_q.size()), 64'd0);
        checkOutput("busy_clear", 64'(lineBusy), 64'd0);
    endtask

    task automatic waitSignal(input string tag, input bit want_read, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (want_read ? ddr.read : ddr.write) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk133_p);
        end
        checkOutput(tag, 64'(seen), 64'd1);
    endtask

    task automatic checkReset();
        checkOutput("rst_read", 64'(ddr.read), 64'd0);
        checkOutput("rst_write", 64'(ddr.write), 64'd0);
        checkOutput("rst_read_addr", 64'(ddr.readAddress), 64'd0);
        checkOutput("rst_write_addr", 64'(ddr.writeAddress), 64'd0);
        checkOutput("rst_write_data", 64'(ddr.writeData), 64'd0);
        checkOutput("rst_line_busy", 64'(lineBusy), 64'd0);
        checkOutput("rst_overrun", 64'(overrun), 64'd0);
        checkOutput("rst_buf_data", 64'(bufReadData), 64'd0);
        checkOutput("rst_pixel_ready", 64'(pixelReady), 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start_count;
        logic [15:0] exp_word;

        repeat (3) @(negedge clk133_p);
        checkReset();
        rst = 1'b0;

        $display("[TB] line fill from 0x000100");
        start_count = reads_done;
        startLine(24'h000100, 1'b1);
        waitQuiet(300);
        checkOutput("reads_per_line", 64'(reads_done - start_count), 64'(LINE_WORDS));

        $display("[TB] single pixel write");
        start_count = writes_done;
        applyStimulus(24'h123456, 16'hBEEF, 1'b1);
        pixelWrite = 1'b0;
        waitSignal("write_raised", 1'b0, 20);
        checkOutput("wr_addr", 64'(ddr.writeAddress), 64'h123456);
        checkOutput("wr_data", 64'(ddr.writeData), 64'hBEEF);
        waitQuiet(100);
        checkOutput("writes_single", 64'(writes_done - start_count), 64'd1);
        checkOutput("ready_after_write", 64'(pixelReady), 64'd1);

        $display("[TB] bank swap and readback");
        startLine(24'h000200, 1'b1);
        for (int i = 0; i < LINE_WORDS; i++) begin
            bufReadAddr = 10'(i);
            @(negedge clk133_p);
            exp_word = 16'(24'h000100 + 24'(i)) ^ 16'hA5A5;
            checkOutput("buf_word", 64'(bufReadData), 64'(exp_word));
        end

        $display("[TB] reset during read");
        waitSignal("read_before_reset", 1'b1, 40);
        @(posedge clk133_p);
        #3;
        rst = 1'b1;
        #1;
        checkReset();
        exp_q.delete();
        @(negedge clk133_p);
        @(negedge clk133_p);
        rst = 1'b0;

        $display("[TB] read priority over queued write");
        start_count = reads_done;
        applyStimulus(24'h00A000, 16'h1111, 1'b1);
        applyStimulus(24'h00A001, 16'h2222, 1'b0);
        pixelWrite = 1'b0;
        waitSignal("first_write_in_flight", 1'b0, 20);
        startLine(24'h000300, 1'b1);
        exp_q.push_back({1'b1, 24'h00A001, 16'h2222});
        waitQuiet(400);
        checkOutput("reads_priority", 64'(reads_done - start_count), 64'(LINE_WORDS));

        $display("[TB] FIFO full with stalled acknowledges");
        start_count = writes_done;
        stall_writes = 1'b1;
        for (int k = 0; k < FIFO_DEPTH + 1; k++) begin
            applyStimulus(24'h400000 + 24'(k), 16'h1000 + 16'(k), k < FIFO_DEPTH);
            checkOutput("pixel_ready", 64'(pixelReady), 64'((k + 1) < FIFO_DEPTH));
        end
        pixelWrite = 1'b0;
        repeat (4) @(negedge clk133_p);
        stall_writes = 1'b0;
        waitQuiet(400);
        checkOutput("writes_full", 64'(writes_done - start_count), 64'(FIFO_DEPTH));

        $display("[TB] address wrap and overrun");
        checkOutput("overrun_clear", 64'(overrun), 64'd0);
        start_count = reads_done;
        startLine(24'hFFFFFE, 1'b1);
        repeat (3) @(negedge clk133_p);
        startLine(24'h555555, 1'b0);
        checkOutput("overrun_set", 64'(overrun), 64'd1);
        waitQuiet(300);
        checkOutput("reads_wrap", 64'(reads_done - start_count), 64'(LINE_WORDS));
        checkOutput("overrun_sticky", 64'(overrun), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
